// File: rtl/atm_txn_arbiter.sv
// Two-terminal ATM transaction arbiter: round-robin grant, fixed four-state
// sequence, and a small balance table updated in the EXEC cycle.
module atm_txn_arbiter #(
  parameter int          N_ACCT   = 3,
  parameter logic [11:0] INIT_BAL = 12'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic        req_b,
  input  logic [1:0]  op_a,
  input  logic [1:0]  op_b,
  input  logic [1:0]  src_a,
  input  logic [1:0]  src_b,
  input  logic [1:0]  dst_a,
  input  logic [1:0]  dst_b,
  input  logic [5:0]  amt_a,
  input  logic [5:0]  amt_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic        done_a,
  output logic        done_b,
  output logic [1:0]  status,
  output logic [11:0] bal_out,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, GRANT, EXEC, RESP} state_t;
  typedef enum logic [1:0] {OP_DEP, OP_WDR, OP_XFR, OP_QRY} op_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_INSUF = 2'b01;
  localparam logic [1:0] ST_BAD   = 2'b10;
  localparam logic [1:0] ST_OVF   = 2'b11;
  localparam logic [2:0] N_LIM    = 3'(N_ACCT);

  state_t      state, state_nxt;
  logic        sel_b, prio_b, pick_b;
  op_t         op_q;
  logic [1:0]  src_q, dst_q;
  logic [5:0]  amt_q;
  logic [11:0] bal [N_ACCT];

  logic        src_ok, dst_ok, bad;
  logic [11:0] amt12, src_bal, dst_bal, src_diff;
  logic [12:0] src_sum, dst_sum;
  logic [1:0]  res_status;
  logic [11:0] res_bal, src_wdata, dst_wdata;
  logic        wr_src, wr_dst;

  // B wins a tie only when A was served last; a lone requester always wins.
  assign pick_b = req_b && (!req_a || prio_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    state_nxt = state;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    done_a    = 1'b0;
    done_b    = 1'b0;
    case (state)
      IDLE:  if (req_a || req_b) state_nxt = GRANT;
      GRANT: begin
        state_nxt = EXEC;
        gnt_a     = !sel_b;
        gnt_b     = sel_b;
      end
      EXEC:  state_nxt = RESP;
      RESP: begin
        state_nxt = IDLE;
        done_a    = !sel_b;
        done_b    = sel_b;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_b  <= 1'b0;
      prio_b <= 1'b0;
      op_q   <= OP_DEP;
      src_q  <= '0;
      dst_q  <= '0;
      amt_q  <= '0;
    end else if (state == IDLE && (req_a || req_b)) begin
      sel_b  <= pick_b;
      prio_b <= !pick_b;
      op_q   <= op_t'(pick_b ? op_b : op_a);
      src_q  <= pick_b ? src_b : src_a;
      dst_q  <= pick_b ? dst_b : dst_a;
      amt_q  <= pick_b ? amt_b : amt_a;
    end
  end

  assign src_ok   = {1'b0, src_q} < N_LIM;
  assign dst_ok   = {1'b0, dst_q} < N_LIM;
  assign amt12    = {6'b0, amt_q};
  // A nonexistent source account reads as zero balance.
  assign src_bal  = src_ok ? bal[src_q] : '0;
  assign dst_bal  = dst_ok ? bal[dst_q] : '0;
  assign src_sum  = {1'b0, src_bal} + {1'b0, amt12};
  assign dst_sum  = {1'b0, dst_bal} + {1'b0, amt12};
  assign src_diff = src_bal - amt12;
  assign bad      = !src_ok || (op_q != OP_QRY && amt_q == '0) ||
                    (op_q == OP_XFR && (!dst_ok || dst_q == src_q));

  // Checks run bad -> insufficient -> overflow; only a clean result writes.
  always_comb begin
    res_status = ST_OK;
    wr_src     = 1'b0;
    wr_dst     = 1'b0;
    src_wdata  = src_bal;
    dst_wdata  = dst_bal;
    if (bad) begin
      res_status = ST_BAD;
    end else begin
      case (op_q)
        OP_DEP: begin
          if (src_sum[12]) res_status = ST_OVF;
          else begin
            wr_src    = 1'b1;
            src_wdata = src_sum[11:0];
          end
        end
        OP_WDR: begin
          if (amt12 > src_bal) res_status = ST_INSUF;
          else begin
            wr_src    = 1'b1;
            src_wdata = src_diff;
          end
        end
        OP_XFR: begin
          if (amt12 > src_bal)  res_status = ST_INSUF;
          else if (dst_sum[12]) res_status = ST_OVF;
          else begin
            wr_src    = 1'b1;
            wr_dst    = 1'b1;
            src_wdata = src_diff;
            dst_wdata = dst_sum[11:0];
          end
        end
        default: ;
      endcase
    end
    res_bal = src_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the table is a handful of flops, so it is reset like any register rather than left uninitialised as a RAM would be.
      for (int i = 0; i < N_ACCT; i++) bal[i] <= INIT_BAL;
      status  <= ST_OK;
      bal_out <= '0;
    end else if (state == EXEC) begin
      if (wr_src) bal[src_q] <= src_wdata;
      if (wr_dst) bal[dst_q] <= dst_wdata;
      status  <= res_status;
      bal_out <= res_bal;
    end
  end

endmodule
